// File: rtl/reg_file.sv
// reg_file: 32 x 64-bit general-purpose register file for the single-cycle
// datapath. Two independent combinational read ports, one synchronous write
// port, a hardwired-zero register and a same-cycle write-to-read bypass so
// that decode sees the value being written back in the same cycle.
module reg_file #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int                    NUM_REGS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // A write is live only out of reset; this also gates the bypass so reads
  // stay at zero while reset is held, even if reg_write is asserted.
  logic write_live;
  assign write_live = reg_write && rst_n;

  // Storage: async clear of every entry, otherwise capture the write-back
  // value on the rising edge; writes to the zero register are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (reg_write && (write_reg != ZERO_IDX)) begin
      regs[write_reg] <= write_data;
    end
  end

  // Port 1 read: zero register first, then bypass of the in-flight write,
  // then the stored entry.
  always_comb begin
    read_data1 = regs[read_reg1];
    if (read_reg1 == ZERO_IDX) begin
      read_data1 = '0;
    end else if (write_live && (write_reg == read_reg1)) begin
      read_data1 = write_data;
    end
  end

  // Port 2 read: same priority as port 1, fully independent of it.
  always_comb begin
    read_data2 = regs[read_reg2];
    if (read_reg2 == ZERO_IDX) begin
      read_data2 = '0;
    end else if (write_live && (write_reg == read_reg2)) begin
      read_data2 = write_data;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file. Expected read values are queued
// as each read is set up and popped when the combinational outputs settle.
module tb_reg_file;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam logic [AW-1:0] XZR = 5'd31;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] read_reg1, read_reg2, write_reg;
  logic [DW-1:0] write_data;
  logic          reg_write;
  logic [DW-1:0] read_data1, read_data2;

  logic [DW-1:0] model [32];
  logic [DW-1:0] q1 [$];
  logic [DW-1:0] q2 [$];
  logic [DW-1:0] exp1, exp2;
  int vectors = 0;
  int errors  = 0;

  reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(31)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .read_data1(read_data1), .read_data2(read_data2)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Behavioural expectation of one read port given the current inputs.
  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] idx);
    if (idx == XZR) return '0;
    if (reg_write && rst_n && write_reg == idx) return write_data;
    return model[idx];
  endfunction

  // Model side of a rising edge.
  task automatic model_edge();
    if (rst_n && reg_write && write_reg != XZR) model[write_reg] = write_data;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  // Single write cycle: drive at negedge, commit on posedge, drop enable.
  task automatic do_write(input logic [AW-1:0] idx, input logic [DW-1:0] data);
    @(negedge clk);
    write_reg = idx; write_data = data; reg_write = 1'b1;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    reg_write = 1'b0;
  endtask

  task automatic test_reset();
    // Reset held from the start: outputs zero with no clock edge.
    read_reg1 = 5'd0; read_reg2 = 5'd13; reg_write = 1'b1;
    write_reg = 5'd13; write_data = 64'hAAAA_5555_AAAA_5555;
    q1.push_back(64'd0); q2.push_back(64'd0);
    #1;
    exp1 = q1.pop_front(); exp2 = q2.pop_front(); vectors += 2;
    if (read_data1 !== exp1) begin errors++; $display("[TB] FAIL reset_hold_p1 got %h want %h", read_data1, exp1); end
    if (read_data2 !== exp2) begin errors++; $display("[TB] FAIL reset_hold_p2 got %h want %h", read_data2, exp2); end
    @(negedge clk); reg_write = 1'b0;
    rst_n = 1'b1;
    // Random writes, then assert reset between edges.
    for (int i = 0; i < 8; i++) do_write(AW'($urandom_range(0, 30)), {$urandom, $urandom} | 64'h1);
    do_write(5'd4, 64'h4444);
    do_write(5'd20, 64'h2020);
    #2 rst_n = 1'b0;
    clear_model();
    read_reg1 = 5'd4; read_reg2 = 5'd20;
    q1.push_back(64'd0); q2.push_back(64'd0);
    #1;
    exp1 = q1.pop_front(); exp2 = q2.pop_front(); vectors += 2;
    if (read_data1 !== exp1) begin errors++; $display("[TB] FAIL reset_async_p1 got %h want %h", read_data1, exp1); end
    if (read_data2 !== exp2) begin errors++; $display("[TB] FAIL reset_async_p2 got %h want %h", read_data2, exp2); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      read_reg1 = AW'(i); read_reg2 = AW'(31 - i);
      q1.push_back(64'd0); q2.push_back(64'd0);
      #1;
      exp1 = q1.pop_front(); exp2 = q2.pop_front(); vectors += 2;
      if (read_data1 !== exp1) begin errors++; $display("[TB] FAIL reset_sweep_p1 idx %0d got %h want %h", i, read_data1, exp1); end
      if (read_data2 !== exp2) begin errors++; $display("[TB] FAIL reset_sweep_p2 idx %0d got %h want %h", 31 - i, read_data2, exp2); end
    end
    // Reset lands on the same instant as a write edge: clear wins.
    @(negedge clk);
    write_reg = 5'd9; write_data = 64'h9999_9999_9999_9999; reg_write = 1'b1;
    read_reg1 = 5'd9; read_reg2 = 5'd9;
    @(posedge clk);
    rst_n = 1'b0;
    q1.push_back(64'd0); q2.push_back(64'd0);
    #1;
    exp1 = q1.pop_front(); exp2 = q2.pop_front(); vectors += 2;
    if (read_data1 !== exp1) begin errors++; $display("[TB] FAIL reset_midwrite_p1 got %h want %h", read_data1, exp1); end
    if (read_data2 !== exp2) begin errors++; $display("[TB] FAIL reset_midwrite_p2 got %h want %h", read_data2, exp2); end
    @(negedge clk); reg_write = 1'b0; rst_n = 1'b1;
    q1.push_back(64'd0);
    #1;
    exp1 = q1.pop_front(); vectors++;
    if (read_data1 !== exp1) begin errors++; $display("[TB] FAIL reset_midwrite_after got %h want %h", read_data1, exp1); end
  endtask

  task automatic test_write_read();
    do_write(5'd5, 64'h0123_4567_89AB_CDEF);
    read_reg1 = 5'd5; read_reg2 = 5'd5;
    q1.push_back(64'h0123_4567_89AB_CDEF); q2.push_back(64'h0123_4567_89AB_CDEF);
    #1;
    exp1 = q1.pop_front(); exp2 = q2.pop_front(); vectors += 2;
    if (read_data1 !== exp1) begin errors++; $display("[TB] FAIL write_read_p1 got %h want %h", read_data1, exp1); end
    if (read_data2 !== exp2) begin errors++; $display("[TB] FAIL write_read_p2 got %h want %h", read_data2, exp2); end
    read_reg2 = 5'd6;
    q2.push_back(64'd0);
    #1;
    exp2 = q2.pop_front(); vectors++;
    if (read_data2 !== exp2) begin errors++; $display("[TB] FAIL write_read_x6 got %h want %h", read_data2, exp2); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    write_reg = XZR; write_data = '1; reg_write = 1'b1;
    read_reg1 = XZR; read_reg2 = XZR;
    q1.push_back(64'd0); q2.push_back(64'd0);
    #1;
    exp1 = q1.pop_front(); exp2 = q2.pop_front(); vectors += 2;
    if (read_data1 !== exp1) begin errors++; $display("[TB] FAIL zero_nobypass_p1 got %h want %h", read_data1, exp1); end
    if (read_data2 !== exp2) begin errors++; $display("[TB] FAIL zero_nobypass_p2 got %h want %h", read_data2, exp2); end
    @(posedge clk); model_edge();
    @(negedge clk); reg_write = 1'b0;
    for (int c = 0; c < 3; c++) begin
      q1.push_back(64'd0); q2.push_back(64'd0);
      #1;
      exp1 = q1.pop_front(); exp2 = q2.pop_front(); vectors += 2;
      if (read_data1 !== exp1) begin errors++; $display("[TB] FAIL zero_later_p1 cyc %0d got %h want %h", c, read_data1, exp1); end
      if (read_data2 !== exp2) begin errors++; $display("[TB] FAIL zero_later_p2 cyc %0d got %h want %h", c, read_data2, exp2); end
      @(negedge clk);
    end
  endtask

  task automatic test_bypass();
    do_write(5'd7, 64'h10);
    write_reg = 5'd7; write_data = 64'h20; reg_write = 1'b1;
    read_reg1 = 5'd7; read_reg2 = 5'd5;
    q1.push_back(64'h20); q2.push_back(64'h0123_4567_89AB_CDEF);
    #1;
    exp1 = q1.pop_front(); exp2 = q2.pop_front(); vectors += 2;
    if (read_data1 !== exp1) begin errors++; $display("[TB] FAIL bypass_on got %h want %h", read_data1, exp1); end
    if (read_data2 !== exp2) begin errors++; $display("[TB] FAIL bypass_other_port got %h want %h", read_data2, exp2); end
    reg_write = 1'b0;
    q1.push_back(64'h10);
    #1;
    exp1 = q1.pop_front(); vectors++;
    if (read_data1 !== exp1) begin errors++; $display("[TB] FAIL bypass_off got %h want %h", read_data1, exp1); end
  endtask

  task automatic test_write_disable();
    @(negedge clk);
    write_reg = 5'd3; write_data = 64'hDEAD; reg_write = 1'b0;
    @(posedge clk); model_edge();
    @(negedge clk);
    read_reg1 = 5'd3; read_reg2 = 5'd3;
    q1.push_back(64'd0); q2.push_back(64'd0);
    #1;
    exp1 = q1.pop_front(); exp2 = q2.pop_front(); vectors += 2;
    if (read_data1 !== exp1) begin errors++; $display("[TB] FAIL write_disable_p1 got %h want %h", read_data1, exp1); end
    if (read_data2 !== exp2) begin errors++; $display("[TB] FAIL write_disable_p2 got %h want %h", read_data2, exp2); end
  endtask

  task automatic test_sweep();
    logic [DW-1:0] sum, diff;
    for (int i = 0; i < 31; i++) do_write(AW'(i), 64'(i) * 64'h0101_0101_0101_0101);
    for (int i = 30; i >= 0; i--) begin
      @(negedge clk);
      read_reg1 = AW'(i); read_reg2 = AW'(i);
      q1.push_back(64'(i) * 64'h0101_0101_0101_0101);
      q2.push_back(64'(i) * 64'h0101_0101_0101_0101);
      #1;
      exp1 = q1.pop_front(); exp2 = q2.pop_front(); vectors += 2;
      if (read_data1 !== exp1) begin errors++; $display("[TB] FAIL sweep_p1 idx %0d got %h want %h", i, read_data1, exp1); end
      if (read_data2 !== exp2) begin errors++; $display("[TB] FAIL sweep_p2 idx %0d got %h want %h", i, read_data2, exp2); end
    end
    do_write(5'd1, 64'd9);
    do_write(5'd2, 64'd4);
    read_reg1 = 5'd1; read_reg2 = 5'd2;
    q1.push_back(64'd13); q2.push_back(64'd5);
    #1;
    sum = read_data1 + read_data2; diff = read_data1 - read_data2;
    exp1 = q1.pop_front(); exp2 = q2.pop_front(); vectors += 2;
    if (sum !== exp1) begin errors++; $display("[TB] FAIL alu_add got %0d want %0d", sum, exp1); end
    if (diff !== exp2) begin errors++; $display("[TB] FAIL alu_sub got %0d want %0d", diff, exp2); end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      write_reg  = AW'($urandom_range(0, 31));
      write_data = {$urandom, $urandom};
      reg_write  = 1'($urandom_range(0, 1));
      read_reg1  = ($urandom_range(0, 2) == 0) ? write_reg : AW'($urandom_range(0, 31));
      read_reg2  = ($urandom_range(0, 2) == 0) ? write_reg : AW'($urandom_range(0, 31));
      q1.push_back(model_read(read_reg1)); q2.push_back(model_read(read_reg2));
      #1;
      exp1 = q1.pop_front(); exp2 = q2.pop_front(); vectors += 2;
      if (read_data1 !== exp1) begin errors++; $display("[TB] FAIL b2b_p1 cyc %0d idx %0d got %h want %h", c, read_reg1, read_data1, exp1); end
      if (read_data2 !== exp2) begin errors++; $display("[TB] FAIL b2b_p2 cyc %0d idx %0d got %h want %h", c, read_reg2, read_data2, exp2); end
      @(posedge clk); model_edge();
    end
    @(negedge clk); reg_write = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; reg_write = 1'b0;
    read_reg1 = '0; read_reg2 = '0; write_reg = '0; write_data = '0;
    clear_model();
    #2 rst_n = 1'b0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_write_disable();
    test_sweep();
    test_back_to_back();
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d/%0d entries want 0", q1.size(), q2.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
